// File: rtl/fp8_to_bf16_unpack_pkg.sv
// rtl/fp8_to_bf16_unpack_pkg.sv - shared FP8/BF16 format constants and unpacker types
package fp8_to_bf16_unpack_pkg;

    // Format constants shared with the BF16->FP8 encoder
    localparam int          FP8_EXP_BIAS          = 8;
    localparam int          BF16_EXP_BIAS         = 127;
    localparam logic [7:0]  FP8_TO_BF16_EXP_DELTA = 8'd119;
    localparam logic [3:0]  FP8_EXP_SPECIAL       = 4'hF;
    localparam logic [14:0] BF16_INF_MAG          = 15'h7F80;
    localparam logic [14:0] BF16_QNAN_MAG         = 15'h7FC0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } unpack_state_e;

    // Lane index width; a single-lane build still carries a 1-bit index
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/fp8_to_bf16_unpack_if.sv
// rtl/fp8_to_bf16_unpack_if.sv - FP8 beat input and BF16 value output stream bundle
interface fp8_to_bf16_unpack_if
    import fp8_to_bf16_unpack_pkg::*;
#(
    parameter int LANES = 4
);
    localparam int LW = lane_w(LANES);

    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_bf16;
    logic [LW-1:0]        out_lane;
    logic                 out_last;
    logic                 out_special;

    // Producer of FP8 beats and consumer of BF16 values
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_bf16, out_lane, out_last, out_special
    );

    // The unpacker itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_bf16, out_lane, out_last, out_special
    );

endinterface

// File: rtl/fp8_to_bf16_lane.sv
// rtl/fp8_to_bf16_lane.sv - combinational decode of one FP8 code into BF16
module fp8_to_bf16_lane
    import fp8_to_bf16_unpack_pkg::*;
(
    input  logic [7:0]  code,
    output logic [15:0] bf16,
    output logic        special
);

    logic       sgn;
    logic [3:0] exp_f;
    logic [2:0] man_f;

    assign sgn   = code[7];
    assign exp_f = code[6:3];
    assign man_f = code[2:0];

    // Zero exponent flushes to signed zero (the encoder never emits subnormals);
    // all-ones exponent is Inf or quiet NaN; otherwise rebias and pad the mantissa
    always_comb begin
        bf16    = 16'h0000;
        special = (exp_f == FP8_EXP_SPECIAL);
        if (exp_f == 4'h0) begin
            bf16 = {sgn, 15'h0000};
        end else if (special) begin
            bf16 = {sgn, (man_f == 3'b000) ? BF16_INF_MAG : BF16_QNAN_MAG};
        end else begin
            bf16 = {sgn, {4'h0, exp_f} + FP8_TO_BF16_EXP_DELTA, man_f, 4'b0000};
        end
    end

endmodule

// File: rtl/fp8_to_bf16_unpack.sv
// rtl/fp8_to_bf16_unpack.sv - streaming FP8 beat to per-lane BF16 value widener
module fp8_to_bf16_unpack
    import fp8_to_bf16_unpack_pkg::*;
#(
    parameter int LANES = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    fp8_to_bf16_unpack_if.slave  bus
);

    localparam int LW = lane_w(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    unpack_state_e       state_q;
    unpack_state_e       state_d;
    logic [8*LANES-1:0]  hold_q;
    logic                last_q;
    logic [LW-1:0]       lane_q;

    logic                final_lane;
    logic                in_fire;
    logic                out_fire;
    logic [7:0]          lane_code;
    logic [15:0]         lane_bf16;
    logic                lane_special;

    assign final_lane = (lane_q == LAST_LANE);
    assign in_fire    = bus.in_valid && bus.in_ready;
    assign out_fire   = bus.out_valid && bus.out_ready;

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load on accept, leave DRAIN only when the last lane goes with nothing behind it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_DRAIN;
            ST_DRAIN: if (out_fire && final_lane && !bus.in_valid) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Stream outputs; in_ready looks at out_ready combinationally so a new beat lands with no bubble
    always_comb begin
        bus.out_valid   = (state_q == ST_DRAIN);
        bus.in_ready    = (state_q == ST_EMPTY) || (bus.out_ready && final_lane);
        bus.out_bf16    = lane_bf16;
        bus.out_special = lane_special;
        bus.out_lane    = lane_q;
        bus.out_last    = last_q && final_lane;
    end

    // Holding register and lane counter; the beat only changes on an input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            last_q <= 1'b0;
            lane_q <= '0;
        end else if (in_fire) begin
            hold_q <= bus.in_data;
            last_q <= bus.in_last;
            lane_q <= '0;
        end else if (out_fire && !final_lane) begin
            lane_q <= lane_q + LW'(1);
        end
    end

    // Lane mux from the held beat only, so decode never sees in_data directly
    always_comb begin
        lane_code = hold_q[7:0];
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == LW'(k)) lane_code = hold_q[8*k +: 8];
        end
    end

    fp8_to_bf16_lane u_lane (
        .code    (lane_code),
        .bf16    (lane_bf16),
        .special (lane_special)
    );

endmodule

// File: tb/tb_fp8_to_bf16_unpack.sv
// tb/tb_fp8_to_bf16_unpack.sv - directed self-checking bench for the FP8 to BF16 unpacker
module tb_fp8_to_bf16_unpack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp8_to_bf16_unpack_if #(.LANES(4)) if4 ();
    fp8_to_bf16_unpack_if #(.LANES(1)) if1 ();

    fp8_to_bf16_unpack #(.LANES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    fp8_to_bf16_unpack #(.LANES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int total = 0;
    int fails = 0;

    logic [15:0] exp_a [4] = '{16'h0000, 16'h3F80, 16'h7F80, 16'hBFC0};
    logic [15:0] exp_b [8] = '{16'h0000, 16'h8000, 16'hFFC0, 16'h3C80,
                               16'h3C00, 16'h4000, 16'h3F00, 16'h3F70};
    logic [7:0]  d1_code [7] = '{8'h40, 8'hC4, 8'h10, 8'h80, 8'h05, 8'h78, 8'hF9};
    logic [15:0] d1_exp  [7] = '{16'h3F80, 16'hBFC0, 16'h3C80, 16'h8000, 16'h0000, 16'h7F80, 16'hFFC0};
    logic        d1_spc  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out4(input string tag, input int lane, input logic [15:0] bf,
                            input logic last, input logic spc);
        chk({tag, "_valid"},   32'(if4.out_valid),   32'd1);
        chk({tag, "_lane"},    32'(if4.out_lane),    32'(lane));
        chk({tag, "_bf16"},    32'(if4.out_bf16),    32'(bf));
        chk({tag, "_last"},    32'(if4.out_last),    32'(last));
        chk({tag, "_special"}, 32'(if4.out_special), 32'(spc));
    endtask

    // Reference decode built from the numeric meaning of the exponent
    function automatic logic [15:0] ref_bf16(input logic [7:0] c);
        logic       s;
        int         e;
        logic [2:0] m;
        logic [7:0] be;
        s = c[7];
        e = int'(c[6:3]);
        m = c[2:0];
        if (e == 0)  return {s, 15'h0000};
        if (e == 15) return (m == 3'b000) ? {s, 15'h7F80} : {s, 15'h7FC0};
        be = 8'(e - 8 + 127);
        return {s, be, m, 4'b0000};
    endfunction

    // Encoder model for round trips of exactly representable values
    function automatic logic [7:0] enc_fp8(input logic [15:0] b);
        logic [7:0] be;
        logic [7:0] fe;
        be = b[14:7];
        if (be == 8'hFF) return {b[15], 4'hF, 3'b000};
        fe = be - 8'd127 + 8'd8;
        return {b[15], fe[3:0], b[6:4]};
    endfunction

    initial begin
        logic [7:0] c;
        logic [3:0] ce;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_last = 1'b0; if4.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid",   32'(if4.out_valid),   32'd0);
        chk("rst_out_lane",    32'(if4.out_lane),    32'd0);
        chk("rst_out_bf16",    32'(if4.out_bf16),    32'h0000);
        chk("rst_out_last",    32'(if4.out_last),    32'd0);
        chk("rst_out_special", 32'(if4.out_special), 32'd0);
        chk("rst_in_ready",    32'(if4.in_ready),    32'd1);
        chk("rst1_in_ready",   32'(if1.in_ready),    32'd1);
        chk("rst1_out_valid",  32'(if1.out_valid),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat, four lanes in consecutive cycles
        @(negedge clk);
        if4.in_data = 32'hC478_4000; if4.in_last = 1'b1; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        #1;
        chk("a_in_ready",  32'(if4.in_ready),  32'd1);
        chk("a_pre_valid", 32'(if4.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if4.in_valid = 1'b0;
            #1;
            chk_out4("a", i, exp_a[i], (i == 3), (i == 2));
        end
        @(negedge clk);
        #1;
        chk("a_post_valid", 32'(if4.out_valid), 32'd0);
        chk("a_post_ready", 32'(if4.in_ready),  32'd1);

        // Back-to-back beats, no bubble
        @(negedge clk);
        if4.in_data = 32'h10F9_8005; if4.in_last = 1'b0; if4.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if4.in_data = 32'h3F38_4808; if4.in_last = 1'b1;
            end
            if (i == 7) if4.in_valid = 1'b0;
            #1;
            chk_out4("b", i % 4, exp_b[i], (i == 7), (i == 2));
            chk("b_in_ready", 32'(if4.in_ready), 32'((i % 4) == 3));
        end
        @(negedge clk);
        #1;
        chk("b_post_valid", 32'(if4.out_valid), 32'd0);

        // Backpressure at lane 2 with a competing beat on the input
        @(negedge clk);
        if4.in_data = 32'hC478_4000; if4.in_last = 1'b0; if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        #1;
        chk_out4("c_l0", 0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_out4("c_l1", 1, 16'h3F80, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (s == 0) begin
                if4.out_ready = 1'b0; if4.in_valid = 1'b1; if4.in_data = 32'hFFFF_FFFF;
            end
            #1;
            chk_out4("c_stall", 2, 16'h7F80, 1'b0, 1'b1);
            chk("c_stall_in_ready", 32'(if4.in_ready), 32'd0);
        end
        @(negedge clk);
        if4.in_valid = 1'b0; if4.out_ready = 1'b1;
        #1;
        chk_out4("c_rel_l2", 2, 16'h7F80, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk_out4("c_rel_l3", 3, 16'hBFC0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("c_post_valid", 32'(if4.out_valid), 32'd0);

        // Asynchronous reset mid-beat
        @(negedge clk);
        if4.in_data = 32'hC478_4000; if4.in_last = 1'b1; if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk_out4("d_l1", 1, 16'h3F80, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("d_async_valid", 32'(if4.out_valid), 32'd0);
        chk("d_async_lane",  32'(if4.out_lane),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("d_post_in_ready",  32'(if4.in_ready),  32'd1);
            chk("d_post_out_valid", 32'(if4.out_valid), 32'd0);
        end

        // Single-lane build: directed codes, one per cycle
        if1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if1.in_valid = (i < 7);
            if (i < 7) if1.in_data = d1_code[i];
            #1;
            chk("l1_in_ready", 32'(if1.in_ready), 32'd1);
            if (i > 0) begin
                chk("l1_valid",   32'(if1.out_valid),   32'd1);
                chk("l1_bf16",    32'(if1.out_bf16),    32'(d1_exp[i-1]));
                chk("l1_special", 32'(if1.out_special), 32'(d1_spc[i-1]));
            end
        end
        @(negedge clk);
        #1;
        chk("l1_post_valid", 32'(if1.out_valid), 32'd0);

        // Single-lane in_ready follows out_ready while holding
        if1.in_valid = 1'b1; if1.in_data = 8'h40; if1.out_ready = 1'b0;
        @(negedge clk);
        if1.in_valid = 1'b0;
        #1;
        chk("l1_bp_valid",    32'(if1.out_valid), 32'd1);
        chk("l1_bp_in_ready", 32'(if1.in_ready),  32'd0);
        if1.out_ready = 1'b1;
        #1;
        chk("l1_rel_in_ready", 32'(if1.in_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("l1_bp_post_valid", 32'(if1.out_valid), 32'd0);

        // Exhaustive sweep with round trip on exactly representable codes
        for (int i = 0; i <= 256; i++) begin
            @(negedge clk);
            if1.in_valid = (i < 256);
            if (i < 256) if1.in_data = 8'(i);
            #1;
            if (i > 0) begin
                c  = 8'(i - 1);
                ce = c[6:3];
                chk("sw_valid",   32'(if1.out_valid),   32'd1);
                chk("sw_bf16",    32'(if1.out_bf16),    32'(ref_bf16(c)));
                chk("sw_special", 32'(if1.out_special), 32'(ce == 4'hF));
                if ((ce >= 4'd2 && ce <= 4'd14) || (ce == 4'hF && c[2:0] == 3'b000))
                    chk("sw_roundtrip", 32'(enc_fp8(if1.out_bf16)), 32'(c));
            end
        end
        @(negedge clk);
        #1;
        chk("sw_post_valid", 32'(if1.out_valid), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
